// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and decode constants for the iterative multiply/divide
// unit (mdu_iter).
//   mdu_op_t    : operation code presented on mdu_iter.op
//   mdu_state_t : sequencer states of mdu_iter
//   FUNCT_*     : R-type funct field values the controller maps onto mdu_op_t
//   decode_funct: funct -> {valid, op} helper for the controller
package mdu_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

  // Returns {valid, op}; valid=0 for funct codes that are not MDU operations.
  function automatic logic [3:0] decode_funct(input logic [5:0] funct);
    case (funct)
      FUNCT_MULT:  decode_funct = {1'b1, MULT};
      FUNCT_MULTU: decode_funct = {1'b1, MULTU};
      FUNCT_DIV:   decode_funct = {1'b1, DIV};
      FUNCT_DIVU:  decode_funct = {1'b1, DIVU};
      FUNCT_MTHI:  decode_funct = {1'b1, MTHI};
      FUNCT_MTLO:  decode_funct = {1'b1, MTLO};
      default:     decode_funct = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mdu_iter_div_step.sv
// mdu_div_step: one combinational iteration of unsigned restoring division.
//   rem_i : partial remainder (always < dvs_i when dvs_i != 0)
//   quo_i : dividend bits still to be consumed (MSB first), quotient bits
//           accumulate from the LSB side
//   dvs_i : divisor magnitude
//   rem_o : next partial remainder
//   quo_o : quo_i shifted left by one with the new quotient bit appended
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // One guard bit: the shifted remainder can reach 2*dvs_i-1, i.e. WIDTH+1 bits.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_i};
    fits    = (shifted >= {1'b0, dvs_i});
    if (fits) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      // Restore: shifted < dvs_i so it fits in WIDTH bits.
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with architectural HI/LO registers.
// Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring), plus MTHI/MTLO.
// Arithmetic runs on operand magnitudes; signs are applied in the FIX state.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset, aborts any operation in flight
//   start : one-cycle request, sampled only while busy=0
//   op    : mdu_op_t operation code (codes 6/7 ignored)
//   a, b  : rs / rt operands
//   busy  : high while an iterative operation is in flight
//   done  : one-cycle pulse when MULT/MULTU/DIV/DIVU wrote hi/lo
//   hi,lo : HI (product upper / remainder) and LO (product lower / quotient)
// Build option: define MDU_FAST_MUL_EN to form products in a single cycle
// (busy for one cycle); division latency and all results are unchanged.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] x);
    // The most-negative value maps onto the unsigned magnitude 2^(WIDTH-1).
    abs_mag = x[WIDTH-1] ? -x : x;
  endfunction

  mdu_state_t         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;     // {hi-part, lo-part}: product or {remainder, quotient}
  logic [WIDTH-1:0]   opb_q;     // multiplicand or divisor magnitude
  logic               is_div_q;
  logic               neg_q;     // negate product / quotient
  logic               neg_r_q;   // negate remainder
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_rem, div_quo;
  logic [2*WIDTH-1:0] acc_step_d;
  logic [WIDTH-1:0]   hi_fix_d, lo_fix_d;

  assign signed_op = (op == MULT) || (op == DIV);
  assign a_mag     = signed_op ? abs_mag(a) : a;
  assign b_mag     = signed_op ? abs_mag(b) : b;

  // Shift-add: the multiplier sits in the low half and is consumed LSB first.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_q[2*WIDTH-1:WIDTH]),
    .quo_i (acc_q[WIDTH-1:0]),
    .dvs_i (opb_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  assign acc_step_d = is_div_q ? {div_rem, div_quo} : {mul_sum, acc_q[WIDTH-1:1]};

  always_comb begin
    hi_fix_d = acc_q[2*WIDTH-1:WIDTH];
    lo_fix_d = acc_q[WIDTH-1:0];
    if (is_div_q) begin
      if (neg_q)   lo_fix_d = -acc_q[WIDTH-1:0];
      if (neg_r_q) hi_fix_d = -acc_q[2*WIDTH-1:WIDTH];
    end else if (neg_q) begin
      {hi_fix_d, lo_fix_d} = -acc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              MULT, MULTU, DIV, DIVU: begin
                is_div_q <= (op == DIV) || (op == DIVU);
                neg_q    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r_q  <= signed_op & a[WIDTH-1];
                cnt_q    <= CNT_W'(WIDTH);
                state_q  <= RUN;
                if ((op == DIV) || (op == DIVU)) begin
                  acc_q <= {{WIDTH{1'b0}}, a_mag};
                  opb_q <= b_mag;
                end else begin
`ifdef MDU_FAST_MUL_EN
                  acc_q   <= {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
                  state_q <= FIX;
`else
                  acc_q   <= {{WIDTH{1'b0}}, b_mag};
`endif
                  opb_q <= a_mag;
                end
              end
              MTHI:    hi_q <= a;
              MTLO:    lo_q <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          acc_q <= acc_step_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_fix_d;
          lo_q    <= lo_fix_d;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_BUSY = 1;
  localparam int INJ_K    = 1;
`else
  localparam int MUL_BUSY = W + 1;
  localparam int INJ_K    = 5;
`endif
  localparam int DIV_BUSY = W + 1;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op    = 3'd0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Architectural result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] model_res(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sp;
    int     sx, sy;
    model_res = '0;
    sx = x;
    sy = y;
    case (o)
      MULT: begin
        sp = longint'(sx) * longint'(sy);
        model_res = sp;
      end
      MULTU: model_res = {32'b0, x} * {32'b0, y};
      DIV: begin
        if (y == 0)
          model_res = {x, (x[W-1] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          model_res = {32'h0, 32'h8000_0000};
        else
          model_res = {32'(sx % sy), 32'(sx / sy)};
      end
      DIVU: begin
        if (y == 0) model_res = {x, 32'hFFFF_FFFF};
        else        model_res = {x % y, x / y};
      end
      default: model_res = '0;
    endcase
  endfunction

  // Transaction-level model: a pending result appears after a fixed busy time.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end else if (start) begin
        case (op)
          MULT, MULTU: begin {p_hi, p_lo} = model_res(op, a, b); m_left = MUL_BUSY; end
          DIV, DIVU:   begin {p_hi, p_lo} = model_res(op, a, b); m_left = DIV_BUSY; end
          MTHI:        m_hi = a;
          MTLO:        m_lo = a;
          default:     ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_ctl", 64'({busy, done}), 64'({(m_left > 0), m_done}));
    chk("cyc_hilo", {hi, lo}, {m_hi, m_lo});
  end

  task automatic run_chk(input string name, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input int ebusy);
    int bc;
    bit got;
    bc  = 0;
    got = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bc++;
      if (done) got = 1'b1;
    end
    chk({name, "_done"}, 64'(got), 64'(1));
    chk({name, "_busy"}, 64'(bc), 64'(ebusy));
    chk({name, "_hilo"}, {hi, lo}, {ehi, elo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 64'({busy, done}), 64'(0));
    chk("rst_hilo", {hi, lo}, 64'(0));
    reset = 1'b0;

    run_chk("mult_neg", MULT, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_BUSY);
    run_chk("multu", MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, MUL_BUSY);
    run_chk("div_m7_2", DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_BUSY);
    run_chk("div_7_m2", DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_BUSY);
    run_chk("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_BUSY);
    run_chk("mult_minmin", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_BUSY);
    run_chk("divu_by0", DIVU, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, DIV_BUSY);
    run_chk("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_BUSY);
    run_chk("div_neg_by0", DIV, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFF8, 32'h0000_0001, DIV_BUSY);
    run_chk("div_pos_by0", DIV, 32'h0000_0005, 32'h0, 32'h0000_0005, 32'hFFFF_FFFF, DIV_BUSY);

    // Second start while busy must be ignored.
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1; op = MULT; a = 32'd3; b = 32'hFFFF_FFFB;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (k == INJ_K) chk("inj_busy", 64'(busy), 64'(1));
      start = (k == INJ_K);
      if (k == INJ_K) begin op = DIVU; a = 32'd100; b = 32'd7; end
    end
    chk("ignore_done_cnt", 64'(done_cnt), 64'(1));
    chk("ignore_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFF1});

    @(negedge clk);
    start = 1'b1; op = MTHI; a = 32'hA5A5_A5A5;
    @(negedge clk);
    start = 1'b0;
    chk("mthi_hi", 64'(hi), 64'(32'hA5A5_A5A5));
    chk("mthi_ctl", 64'({busy, done}), 64'(0));
    start = 1'b1; op = MTLO; a = 32'h5A5A_5A5A;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_hilo", {hi, lo}, {32'hA5A5_A5A5, 32'h5A5A_5A5A});

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = DIV; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_hilo", {hi, lo}, 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("no_done_after_rst", 64'(done_cnt), 64'(0));

    run_chk("multu_ffff", MULTU, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001, MUL_BUSY);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers. It executes the mult/multu operations that the current ALU decode only tags, and adds div/divu plus mthi/mtlo. It sits beside the ALU in the execute stage. The controller starts it with a one-cycle start pulse, stalls on busy, and reads hi/lo (mfhi/mflo) at any time.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits; must be even and >= 4.
CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived, not overridden).

Ports:
clk  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request; sampled only when busy=0.
op  in  3  mdu_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
a  in  WIDTH  rs operand (multiplicand / dividend / mthi-mtlo data).
b  in  WIDTH  rt operand (multiplier / divisor).
busy  out  1  high while an iterative op is in flight.
done  out  1  one-cycle pulse when hi/lo were written by MULT/MULTU/DIV/DIVU.
hi  out  WIDTH  HI register (product upper half / remainder).
lo  out  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset: state=IDLE; hi=0, lo=0, busy=0, done=0, counter=0. Reset asserted mid-operation aborts at once; no partial result reaches hi/lo.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - start=1 with MULT/MULTU/DIV/DIVU latches |a| and |b| (signed ops) or the raw values (unsigned), plus the result signs. Clears the accumulator, loads counter=WIDTH, goes to RUN; busy=1 from the next cycle.
  - start=1 with MTHI writes hi<=a (or MTLO writes lo<=a) at that edge. Stays IDLE; busy and done stay 0.
  - Undefined op codes are ignored.
- RUN: one bit per cycle; counter decrements each cycle; exits to FIX when counter reaches 1.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring algorithm, WIDTH-bit remainder with one guard bit.
- FIX: applies two's-complement sign correction.
  - Product is negated if sign(a) XOR sign(b).
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - Writes hi/lo, pulses done for one cycle, returns to IDLE; busy falls in the same cycle.
- Latency: start sampled at edge E0; busy high for WIDTH+1 cycles; hi/lo valid and done=1 in the cycle after edge E(WIDTH+1).
- start while busy=1 is ignored with no side effects. hi/lo hold their old values until FIX.
- Divide by zero (b=0): no trap; completes with normal latency. DIVU gives lo=all-ones, hi=a. DIV gives lo=all-ones if a>=0 else 1, hi=a.
- Signed overflow DIV (a = most-negative, b = -1): lo=most-negative, hi=0.
- Operand widths: all internal arithmetic is unsigned on magnitudes. Absolute value of the most-negative operand is handled as the unsigned WIDTH-bit value 2^(WIDTH-1).

Optional Feature:
MDU_FAST_MUL_EN:
- Defined: MULT/MULTU skip RUN and compute the full 2*WIDTH product in the IDLE->FIX transition, so busy is high for exactly 1 cycle and done follows one cycle later. Divide latency is unchanged.
- Undefined: multiply is iterative as above.
- Results are bit-identical in both builds.

Decomposition:
- Package mdu_pkg holds:
  - the mdu_op_t enum: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5;
  - the mdu_state_t enum: IDLE, RUN, FIX.
- The aludec funct-to-op mapping constants (011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo) also live there for the controller.
- One natural sub-module, mdu_div_step: the combinational restoring-divide step (remainder/quotient in -> out). The FSM, counter, sign logic and HI/LO stay in mdu_iter.

Test Plan:
1. WIDTH=32, MULT a=0xFFFFFFFF b=0x00000002 -> after 33 busy cycles, done=1; hi=0xFFFFFFFF, lo=0xFFFFFFFE.
2. MULTU a=0xFFFFFFFF b=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE; DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MULT running, second start=1 (DIVU) at cycle 5 -> ignored: the MULT result is unchanged and only one done pulse occurs; then MTHI a=0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5 next cycle, done stays 0.
5. DIV started, reset asserted asynchronously at cycle 10 -> busy=0, hi=lo=0 immediately; no done pulse afterwards.
6. With MDU_FAST_MUL_EN defined, MULTU 0x0000FFFF*0x0000FFFF -> busy exactly 1 cycle; hi=0, lo=0xFFFE0001.
